spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
- SPI target (slave) endpoint. It is the far end of the link driven by our SPI master.
- Oversamples SCLK, CS_N and MOSI in the single system clock domain.
- Deserialises MOSI into N-bit words and serialises a single-entry TX buffer onto MISO.
- Presents a simple write / valid-pulse interface to local logic, with abort reporting when CS_N is released mid-frame.

Parameters:
- N, 8, frame width in bits (N ≥ 2).
- CPOL, 0, SCLK idle level.
- CPHA, 0, 0 = sample on leading edge / shift on trailing edge; 1 = shift on leading edge / sample on trailing edge.

Ports:
- i_clk_p  in  1  system clock; must be at least 8× the SCLK frequency.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_sclk  in  1  SPI clock from master (asynchronous).
- i_cs_n  in  1  chip select, active-low (asynchronous).
- i_mosi  in  1  master-out data (asynchronous).
- o_miso  out  1  slave-out data.
- o_miso_oe  out  1  MISO output enable; high while the frame is active.
- i_tx_data  in  N  word to transmit.
- i_tx_we  in  1  write i_tx_data into the TX buffer.
- o_tx_ready  out  1  TX buffer empty; a write is accepted.
- o_rx_data  out  N  last complete received word.
- o_rx_valid  out  1  one-cycle pulse when o_rx_data updates.
- o_busy  out  1  frame active (synchronised CS_N low).
- o_abort  out  1  one-cycle pulse when CS_N rises with a partial word.

Behaviour:
- Reset (i_rst_n low at a rising edge of i_clk_p):
  - Outputs: o_tx_ready = 1. All other outputs = 0 (o_miso, o_miso_oe, o_rx_data, o_rx_valid, o_busy, o_abort).
  - Synchronisers are preset to idle levels: cs_n = 1, sclk = CPOL, mosi = 0.
  - TX buffer is emptied, bit counter = 0, state = IDLE.
  - Reset mid-frame is silent: no o_abort, no o_rx_valid.
- Input path:
  - 2-FF synchroniser on each of SCLK, CS_N and MOSI.
  - A third SCLK flop gives edge detection.
  - Leading edge = rising if CPOL = 0, falling if CPOL = 1.
- Latency: o_rx_valid is high in the cycle following the 3rd i_clk_p rising edge after the final sampling SCLK pin edge.
- State IDLE:
  - o_busy = 0, o_miso_oe = 0, o_miso = 0.
  - On synchronised CS_N falling, go to ACTIVE with bit_cnt = 0.
  - If CPHA = 0, also load the TX shift register at this point (the load rule is given under TX buffer below).
- State ACTIVE, sampling edge:
  - rx_shift = {rx_shift[N-2:0], mosi_sync}, bit_cnt + 1. Data is MSB first.
  - On the Nth sample: o_rx_data = completed word, o_rx_valid pulses for 1 cycle, bit_cnt wraps to 0.
  - The overwrite of o_rx_data is unconditional; there is no backpressure.
- State ACTIVE, shift edge:
  - CPHA = 0: on the trailing edge, if bit_cnt == 0 (a word just completed), load TX for the next frame; otherwise shift TX left.
  - CPHA = 1: on the leading edge, if bit_cnt == 0, load TX; otherwise shift TX left.
  - o_miso = tx_shift[N-1] throughout ACTIVE.
- Back-to-back words while CS_N stays low are supported without gaps.
- TX buffer:
  - i_tx_we while o_tx_ready = 1: capture i_tx_data and drop o_tx_ready on the next cycle.
  - i_tx_we while o_tx_ready = 0: ignored, buffer unchanged.
  - Load with buffer full: tx_shift = buffer, and o_tx_ready rises on the next cycle.
  - Load with buffer empty (underrun): tx_shift = 0, o_tx_ready stays 1.
  - i_tx_we in the same cycle as a load with the buffer empty: the write goes to the buffer, not the shift register.
- CS_N synchronised rising edge, from any ACTIVE point:
  - Return to IDLE next cycle.
  - If bit_cnt ≠ 0: o_abort pulses 1 cycle, the partial rx_shift is discarded, and o_rx_data is unchanged.
  - If bit_cnt == 0: no abort.
  - The TX buffer content is retained.
- Simultaneous edges:
  - A sampling edge in the same cycle as CS_N rising: CS_N has priority; the edge is ignored.
  - Glitches shorter than 2 i_clk_p cycles are not guaranteed to be filtered.

Test Plan:
- Mode 0, N = 8: write 0x3C, then CS low and 8 SCLK with MOSI = 0xA5. Required: MISO bits 0,0,1,1,1,1,0,0; o_rx_data = 0xA5 with a single o_rx_valid pulse; o_tx_ready returns to 1 after the CS fall load.
- Back-to-back: buffer 0x11 preloaded; write 0x22 after o_tx_ready rises; 16 SCLK under one CS with MOSI 0xF0, 0x0F. Required: MISO 0x11 then 0x22; two o_rx_valid pulses with 0xF0 then 0x0F.
- Underrun: no TX write before the frame. Required: MISO all 0, o_tx_ready stays 1, RX still correct.
- Abort: CS rises after 5 SCLK. Required: o_abort one-cycle pulse, no o_rx_valid, o_rx_data keeps its previous value, o_busy = 0 two cycles later.
- Mode 3 (CPOL = 1, CPHA = 1): TX 0xC3, MOSI 0x5A. Required: MISO 0xC3 driven on falling edges; o_rx_data = 0x5A sampled on rising edges.
- Reset asserted mid-frame at bit 4, then a new full frame. Required: outputs at reset values with o_tx_ready = 1 and no abort; the next 8-bit frame is received correctly.

Source files
------------

// File: rtl/spi_slave_if.sv
// Signal bundle between an SPI target endpoint and its environment: the SPI pins
// plus the local TX-write / RX-valid side. Parameter N must match the endpoint's N.
interface spi_slave_if #(
  parameter int N = 8
);
  logic         i_sclk;
  logic         i_cs_n;
  logic         i_mosi;
  logic         o_miso;
  logic         o_miso_oe;
  logic [N-1:0] i_tx_data;
  logic         i_tx_we;
  logic         o_tx_ready;
  logic [N-1:0] o_rx_data;
  logic         o_rx_valid;
  logic         o_busy;
  logic         o_abort;
  logic         o_state;

  // Handshakes: a TX write is taken only in a cycle where i_tx_we and o_tx_ready are
  // both high; o_rx_valid is a one-cycle pulse with no backpressure, so local logic
  // must capture o_rx_data before the next word completes. o_state: 0 idle, 1 active.
  modport slave (
    input  i_sclk, i_cs_n, i_mosi, i_tx_data, i_tx_we,
    output o_miso, o_miso_oe, o_tx_ready, o_rx_data, o_rx_valid, o_busy, o_abort, o_state
  );

  modport master (
    output i_sclk, i_cs_n, i_mosi, i_tx_data, i_tx_we,
    input  o_miso, o_miso_oe, o_tx_ready, o_rx_data, o_rx_valid, o_busy, o_abort, o_state
  );
endinterface

// File: rtl/spi_slave.sv
// SPI target endpoint: oversamples SCLK/CS_N/MOSI in the i_clk_p domain, receives
// N-bit MSB-first words and transmits from a single-entry TX buffer.
module spi_slave #(
  parameter int N    = 8,
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0
) (
  input  logic        i_clk_p,
  input  logic        i_rst_n,
  spi_slave_if.slave  bus
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] bit_cnt;
  logic [N-1:0]  rx_shift;
  logic [N-1:0]  rx_data;
  logic          rx_valid;
  logic          abort;
  logic          busy;
  logic [N-1:0]  tx_shift;
  logic [N-1:0]  tx_buf;
  logic          tx_ready;

  logic sclk_s1, sclk_s2, sclk_s3;
  logic cs_s1, cs_s2, cs_s3;
  logic mosi_s1, mosi_s2;

  // Synchronisers preset to the idle pin levels so reset never fakes an edge.
  always_ff @(posedge i_clk_p) begin
    if (!i_rst_n) begin
      sclk_s1 <= CPOL;
      sclk_s2 <= CPOL;
      sclk_s3 <= CPOL;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_s3   <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sclk_s1 <= bus.i_sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      cs_s1   <= bus.i_cs_n;
      cs_s2   <= cs_s1;
      cs_s3   <= cs_s2;
      mosi_s1 <= bus.i_mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  logic sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic sample_edge, shift_edge;
  logic cs_fall, cs_high;
  logic load_on_cs, load_in_frame, shift_in_frame, tx_load;
  logic [N-1:0] rx_next;

  assign sclk_rise   = sclk_s2 & ~sclk_s3;
  assign sclk_fall   = ~sclk_s2 & sclk_s3;
  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign cs_fall     = ~cs_s2 & cs_s3;
  assign cs_high     = cs_s2;
  assign rx_next     = {rx_shift[N-2:0], mosi_s2};

  // With CPHA=0 the first MISO bit must be valid before the first SCLK edge,
  // so the shift register is loaded as the frame opens.
  assign load_on_cs     = (state == IDLE) && cs_fall && !CPHA;
  assign load_in_frame  = (state == ACTIVE) && !cs_high && shift_edge && (bit_cnt == '0);
  assign shift_in_frame = (state == ACTIVE) && !cs_high && shift_edge && (bit_cnt != '0);
  assign tx_load        = load_on_cs | load_in_frame;

  always_ff @(posedge i_clk_p) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      abort    <= 1'b0;
      busy     <= 1'b0;
      tx_shift <= '0;
      tx_buf   <= '0;
      tx_ready <= 1'b1;
    end else begin
      rx_valid <= 1'b0;
      abort    <= 1'b0;

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state    <= ACTIVE;
            busy     <= 1'b1;
            bit_cnt  <= '0;
            rx_shift <= '0;
          end
        end
        ACTIVE: begin
          // CS_N release wins over any SCLK edge seen in the same cycle.
          if (cs_high) begin
            state   <= IDLE;
            busy    <= 1'b0;
            bit_cnt <= '0;
            if (bit_cnt != '0) abort <= 1'b1;
          end else if (sample_edge) begin
            rx_shift <= rx_next;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt  <= '0;
              rx_data  <= rx_next;
              rx_valid <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (shift_in_frame) tx_shift <= {tx_shift[N-2:0], 1'b0};

      // Underrun sends zeros; a write landing in the same cycle still fills the buffer.
      if (tx_load) begin
        if (!tx_ready) begin
          tx_shift <= tx_buf;
          tx_ready <= 1'b1;
        end else begin
          tx_shift <= '0;
        end
      end

      if (bus.i_tx_we && tx_ready) begin
        tx_buf   <= bus.i_tx_data;
        tx_ready <= 1'b0;
      end
    end
  end

  assign bus.o_miso     = (state == ACTIVE) & tx_shift[N-1];
  assign bus.o_miso_oe  = busy;
  assign bus.o_busy     = busy;
  assign bus.o_tx_ready = tx_ready;
  assign bus.o_rx_data  = rx_data;
  assign bus.o_rx_valid = rx_valid;
  assign bus.o_abort    = abort;
  assign bus.o_state    = state;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a mode 0 instance and a mode 3 instance, each driven
// by its own SPI master model, with hand-computed expected words.
module tb_spi_slave;

  logic clk;
  logic rst_n;

  spi_slave_if #(.N(8)) bus0 ();
  spi_slave_if #(.N(8)) bus3 ();

  spi_slave #(.N(8), .CPOL(1'b0), .CPHA(1'b0)) u_m0 (
    .i_clk_p (clk),
    .i_rst_n (rst_n),
    .bus     (bus0)
  );

  spi_slave #(.N(8), .CPOL(1'b1), .CPHA(1'b1)) u_m3 (
    .i_clk_p (clk),
    .i_rst_n (rst_n),
    .bus     (bus3)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Scoreboard capture of every RX pulse and abort pulse, sampled mid-cycle.
  logic [7:0] rx0_q[$];
  logic [7:0] rx3_q[$];
  int abort0_cnt = 0;
  int abort3_cnt = 0;

  always @(negedge clk) begin
    if (bus0.o_rx_valid) rx0_q.push_back(bus0.o_rx_data);
    if (bus3.o_rx_valid) rx3_q.push_back(bus3.o_rx_data);
    if (bus0.o_abort) abort0_cnt++;
    if (bus3.o_abort) abort3_cnt++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pop_rx(input bit m3);
    if (m3) return (rx3_q.size() == 0) ? 16'hFFFF : {8'h00, rx3_q.pop_front()};
    return (rx0_q.size() == 0) ? 16'hFFFF : {8'h00, rx0_q.pop_front()};
  endfunction

  // Driver tasks
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_write(input bit m3, input logic [7:0] d);
    if (m3) begin bus3.i_tx_data = d; bus3.i_tx_we = 1'b1; end
    else    begin bus0.i_tx_data = d; bus0.i_tx_we = 1'b1; end
    wait_clks(1);
    bus0.i_tx_we = 1'b0;
    bus3.i_tx_we = 1'b0;
    wait_clks(1);
  endtask

  task automatic cs_set(input bit m3, input logic v);
    if (m3) bus3.i_cs_n = v;
    else    bus0.i_cs_n = v;
    wait_clks(8);
  endtask

  // Master samples MISO just before its sampling edge; mode 3 drives on falling SCLK.
  task automatic xfer(input bit m3, input int nbits, input logic [15:0] mo,
                      output logic [15:0] mi);
    mi = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      if (!m3) begin
        bus0.i_mosi = mo[i];
        wait_clks(8);
        mi = {mi[14:0], bus0.o_miso};
        bus0.i_sclk = 1'b1;
        wait_clks(8);
        bus0.i_sclk = 1'b0;
      end else begin
        bus3.i_sclk = 1'b0;
        bus3.i_mosi = mo[i];
        wait_clks(8);
        mi = {mi[14:0], bus3.o_miso};
        bus3.i_sclk = 1'b1;
        wait_clks(8);
      end
    end
    wait_clks(8);
  endtask

  logic [15:0] miso_word;
  int          abort_base;

  initial begin
    rst_n = 1'b0;
    bus0.i_sclk = 1'b0; bus0.i_cs_n = 1'b1; bus0.i_mosi = 1'b0;
    bus0.i_tx_data = '0; bus0.i_tx_we = 1'b0;
    bus3.i_sclk = 1'b1; bus3.i_cs_n = 1'b1; bus3.i_mosi = 1'b0;
    bus3.i_tx_data = '0; bus3.i_tx_we = 1'b0;
    wait_clks(4);

    // Reset state
    check("rst_tx_ready", 16'(bus0.o_tx_ready), 16'h1);
    check("rst_miso",     16'(bus0.o_miso),     16'h0);
    check("rst_miso_oe",  16'(bus0.o_miso_oe),  16'h0);
    check("rst_rx_data",  16'(bus0.o_rx_data),  16'h0);
    check("rst_rx_valid", 16'(bus0.o_rx_valid), 16'h0);
    check("rst_busy",     16'(bus0.o_busy),     16'h0);
    check("rst_abort",    16'(bus0.o_abort),    16'h0);
    check("rst_state",    16'(bus0.o_state),    16'h0);
    check("rst3_tx_ready",16'(bus3.o_tx_ready), 16'h1);
    rst_n = 1'b1;
    wait_clks(4);

    // Mode 0 single word
    tx_write(0, 8'h3C);
    check("t1_ready_low", 16'(bus0.o_tx_ready), 16'h0);
    cs_set(0, 1'b0);
    check("t1_busy",      16'(bus0.o_busy),     16'h1);
    check("t1_miso_oe",   16'(bus0.o_miso_oe),  16'h1);
    check("t1_state",     16'(bus0.o_state),    16'h1);
    check("t1_ready_up",  16'(bus0.o_tx_ready), 16'h1);
    xfer(0, 8, 16'h00A5, miso_word);
    check("t1_miso",      miso_word,            16'h003C);
    cs_set(0, 1'b1);
    check("t1_rx_count",  16'(rx0_q.size()),    16'h1);
    check("t1_rx_word",   pop_rx(0),            16'h00A5);
    check("t1_rx_data",   16'(bus0.o_rx_data),  16'h00A5);
    check("t1_busy_off",  16'(bus0.o_busy),     16'h0);
    check("t1_no_abort",  16'(abort0_cnt),      16'h0);

    // Back-to-back words under one CS
    tx_write(0, 8'h11);
    cs_set(0, 1'b0);
    check("t2_ready_up",  16'(bus0.o_tx_ready), 16'h1);
    tx_write(0, 8'h22);
    check("t2_ready_low", 16'(bus0.o_tx_ready), 16'h0);
    xfer(0, 16, 16'hF00F, miso_word);
    check("t2_miso",      miso_word,            16'h1122);
    cs_set(0, 1'b1);
    check("t2_rx_count",  16'(rx0_q.size()),    16'h2);
    check("t2_rx_word0",  pop_rx(0),            16'h00F0);
    check("t2_rx_word1",  pop_rx(0),            16'h000F);
    check("t2_ready_end", 16'(bus0.o_tx_ready), 16'h1);

    // Underrun: nothing written
    cs_set(0, 1'b0);
    xfer(0, 8, 16'h0069, miso_word);
    check("t3_miso_zero", miso_word,            16'h0000);
    check("t3_ready",     16'(bus0.o_tx_ready), 16'h1);
    cs_set(0, 1'b1);
    check("t3_rx_word",   pop_rx(0),            16'h0069);
    check("t3_rx_empty",  16'(rx0_q.size()),    16'h0);

    // Abort after 5 bits
    cs_set(0, 1'b0);
    xfer(0, 5, 16'h0016, miso_word);
    bus0.i_cs_n = 1'b1;
    wait_clks(5);
    check("t4_busy_off",  16'(bus0.o_busy),     16'h0);
    wait_clks(3);
    check("t4_abort_cnt", 16'(abort0_cnt),      16'h1);
    check("t4_no_rx",     16'(rx0_q.size()),    16'h0);
    check("t4_rx_kept",   16'(bus0.o_rx_data),  16'h0069);
    check("t4_abort_low", 16'(bus0.o_abort),    16'h0);

    // Mode 3
    tx_write(1, 8'hC3);
    cs_set(1, 1'b0);
    check("t5_busy",      16'(bus3.o_busy),     16'h1);
    xfer(1, 8, 16'h005A, miso_word);
    check("t5_miso",      miso_word,            16'h00C3);
    cs_set(1, 1'b1);
    check("t5_rx_count",  16'(rx3_q.size()),    16'h1);
    check("t5_rx_word",   pop_rx(1),            16'h005A);
    check("t5_rx_data",   16'(bus3.o_rx_data),  16'h005A);
    check("t5_no_abort",  16'(abort3_cnt),      16'h0);
    check("t5_m0_quiet",  16'(rx0_q.size()),    16'h0);

    // Reset in the middle of a frame, then a clean frame
    abort_base = abort0_cnt;
    tx_write(0, 8'h96);
    cs_set(0, 1'b0);
    xfer(0, 4, 16'h000B, miso_word);
    rst_n = 1'b0;
    wait_clks(3);
    check("t6_ready",     16'(bus0.o_tx_ready), 16'h1);
    check("t6_busy",      16'(bus0.o_busy),     16'h0);
    check("t6_miso_oe",   16'(bus0.o_miso_oe),  16'h0);
    check("t6_miso",      16'(bus0.o_miso),     16'h0);
    check("t6_rx_data",   16'(bus0.o_rx_data),  16'h0);
    bus0.i_cs_n = 1'b1;
    wait_clks(2);
    rst_n = 1'b1;
    wait_clks(8);
    check("t6_no_abort",  16'(abort0_cnt - abort_base), 16'h0);
    check("t6_no_rx",     16'(rx0_q.size()),    16'h0);
    check("t6_state",     16'(bus0.o_state),    16'h0);
    tx_write(0, 8'hE7);
    cs_set(0, 1'b0);
    xfer(0, 8, 16'h003D, miso_word);
    check("t6_miso",      miso_word,            16'h00E7);
    cs_set(0, 1'b1);
    check("t6_rx_word",   pop_rx(0),            16'h003D);
    check("t6_rx_data2",  16'(bus0.o_rx_data),  16'h003D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
